// File: rtl/lift_pkg.sv
// Shared types and call-scan helpers for the N-floor lift controller.
// Pure combinational helpers; no state, no latency.
package lift_pkg;

    localparam int MAX_FLOORS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        MOVE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_t;

    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] v, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > f && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] v, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < f && v[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter: done is high while the count is at its last cycle (<=1).
// Load takes effect on the next edge; counts only when enabled, holds at zero.
module lift_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt <= W'(1));

endmodule

// File: rtl/lift_ctrl_n.sv
// Single-car N-floor lift controller with directional collector scheduling.
// Calls latch one edge after sampling; door/motion commands decode straight from state.
module lift_ctrl_n
    import lift_pkg::*;
#(
    parameter  int FLOORS      = 4,
    parameter  int DOOR_TIME   = 8,
    parameter  int TRAVEL_TIME = 4,
    localparam int FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] car_call,
    input  logic [FLOORS-1:0] hall_up,
    input  logic [FLOORS-1:0] hall_dn,
    input  logic              door_hold,
    output logic [FW-1:0]     floor_pos,
    output logic              door_open,
    output logic              move_up,
    output logic              move_dn,
    output logic [FLOORS-1:0] pend_car,
    output logic [FLOORS-1:0] pend_up,
    output logic [FLOORS-1:0] pend_dn
);

    localparam int TMAX = (DOOR_TIME > TRAVEL_TIME) ? DOOR_TIME : TRAVEL_TIME;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    state_t state, state_nxt;
    dir_t   dir, dir_nxt;

    logic [FW-1:0]         floor_nxt, nf;
    logic [FLOORS-1:0]     hall_up_m, hall_dn_m;
    logic [FLOORS-1:0]     clr_car, clr_up, clr_dn;
    logic [FLOORS-1:0]     oh_cur, oh_nf;
    logic [MAX_FLOORS-1:0] pend_w;
    logic above_cur, below_cur, above_nf, below_nf, ahead_cur, ahead_nf;
    logic su_cur, sd_cur, su_nf, sd_nf;
    logic hit_cur, req_cur, stop_nf, at_end;
    logic door_load, door_done, trav_load, trav_done;

    assign hall_up_m = hall_up & UP_MASK;
    assign hall_dn_m = hall_dn & DN_MASK;
    assign pend_w    = MAX_FLOORS'(pend_car | pend_up | pend_dn);

    assign nf     = (dir == DN) ? floor_pos - FW'(1) : floor_pos + FW'(1);
    assign oh_cur = FLOORS'(1) << floor_pos;
    assign oh_nf  = FLOORS'(1) << nf;

    assign above_cur = calls_above(pend_w, int'(floor_pos));
    assign below_cur = calls_below(pend_w, int'(floor_pos));
    assign above_nf  = calls_above(pend_w, int'(nf));
    assign below_nf  = calls_below(pend_w, int'(nf));
    assign ahead_cur = (dir == UP) ? above_cur : (dir == DN) ? below_cur : 1'b0;
    assign ahead_nf  = (dir == UP) ? above_nf  : below_nf;

    // A hall call counts as served when it matches the direction, or nothing lies ahead.
    assign su_cur = (dir != DN) || !ahead_cur;
    assign sd_cur = (dir != UP) || !ahead_cur;
    assign su_nf  = (dir == UP) || !ahead_nf;
    assign sd_nf  = (dir == DN) || !ahead_nf;

    assign hit_cur = pend_car[floor_pos] | (pend_up[floor_pos] & su_cur) | (pend_dn[floor_pos] & sd_cur);
    assign req_cur = car_call[floor_pos] | (hall_up_m[floor_pos] & su_cur) | (hall_dn_m[floor_pos] & sd_cur);
    assign at_end  = ((dir == UP) && (nf == FW'(FLOORS-1))) || ((dir == DN) && (nf == '0));
    assign stop_nf = pend_car[nf] | ((dir == UP) ? pend_up[nf] : pend_dn[nf]) | !ahead_nf | at_end;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        floor_nxt = floor_pos;
        door_load = 1'b0;
        trav_load = 1'b0;
        clr_car   = '0;
        clr_up    = '0;
        clr_dn    = '0;
        unique case (state)
            IDLE: begin
                if (hit_cur) begin
                    state_nxt = OPEN;
                    door_load = 1'b1;
                    clr_car   = oh_cur;
                    clr_up    = su_cur ? oh_cur : '0;
                    clr_dn    = sd_cur ? oh_cur : '0;
                end else if ((dir == DN) ? below_cur : above_cur) begin
                    state_nxt = MOVE;
                    trav_load = 1'b1;
                    dir_nxt   = (dir == DN) ? DN : UP;
                end else if ((dir == DN) ? above_cur : below_cur) begin
                    state_nxt = MOVE;
                    trav_load = 1'b1;
                    dir_nxt   = (dir == DN) ? UP : DN;
                end else begin
                    dir_nxt = NONE;
                end
            end
            OPEN: begin
                // Requests at the open floor are absorbed here rather than latched.
                clr_car = oh_cur;
                clr_up  = su_cur ? oh_cur : '0;
                clr_dn  = sd_cur ? oh_cur : '0;
                if (door_hold || req_cur) begin
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_nxt = IDLE;
                end
            end
            MOVE: begin
                if (trav_done) begin
                    floor_nxt = nf;
                    if (stop_nf) begin
                        state_nxt = OPEN;
                        door_load = 1'b1;
                        clr_car   = oh_nf;
                        clr_up    = su_nf ? oh_nf : '0;
                        clr_dn    = sd_nf ? oh_nf : '0;
                    end else begin
                        trav_load = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir       <= NONE;
            floor_pos <= '0;
            pend_car  <= '0;
            pend_up   <= '0;
            pend_dn   <= '0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            floor_pos <= floor_nxt;
            pend_car  <= (pend_car | car_call)  & ~clr_car;
            pend_up   <= (pend_up  | hall_up_m) & ~clr_up;
            pend_dn   <= (pend_dn  | hall_dn_m) & ~clr_dn;
        end
    end

    assign door_open = (state == OPEN);
    assign move_up   = (state == MOVE) && (dir == UP);
    assign move_dn   = (state == MOVE) && (dir == DN);

    lift_timer #(.W(TW)) u_door_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (door_load),
        .en       (state == OPEN),
        .load_val (TW'(DOOR_TIME)),
        .done     (door_done)
    );

    lift_timer #(.W(TW)) u_trav_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (trav_load),
        .en       (state == MOVE),
        .load_val (TW'(TRAVEL_TIME)),
        .done     (trav_done)
    );

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Bench for lift_ctrl_n: directed scenarios plus random calls against a floor-level model.
module tb_lift_ctrl_n;

    localparam int FL = 4;
    localparam int DT = 8;
    localparam int TT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FL-1:0] car_call, hall_up, hall_dn;
    logic          door_hold;
    logic [1:0]    floor_pos;
    logic          door_open, move_up, move_dn;
    logic [FL-1:0] pend_car, pend_up, pend_dn;

    int total = 0;
    int bad   = 0;
    int cnt_up, cnt_dn, cnt_door;

    // Reference model: direction is a signed step (+1, -1, 0), m_left counts remaining cycles.
    bit pc[FL], pu[FL], pd[FL];
    int m_floor, m_dir, m_left;
    bit m_door, m_move;

    lift_ctrl_n #(.FLOORS(FL), .DOOR_TIME(DT), .TRAVEL_TIME(TT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .car_call  (car_call),
        .hall_up   (hall_up),
        .hall_dn   (hall_dn),
        .door_hold (door_hold),
        .floor_pos (floor_pos),
        .door_open (door_open),
        .move_up   (move_up),
        .move_dn   (move_dn),
        .pend_car  (pend_car),
        .pend_up   (pend_up),
        .pend_dn   (pend_dn)
    );

    always #5 clk = ~clk;

    function automatic bit ahead(input int f, input int d);
        for (int g = 0; g < FL; g++) begin
            if ((g - f) * d > 0 && (pc[g] || pu[g] || pd[g])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit serves(input int f, input int d, input int h);
        return (d == 0) || (d == h) || !ahead(f, d);
    endfunction

    task automatic m_reset();
        for (int g = 0; g < FL; g++) begin
            pc[g] = 1'b0; pu[g] = 1'b0; pd[g] = 1'b0;
        end
        m_floor = 0; m_dir = 0; m_left = 0; m_door = 1'b0; m_move = 1'b0;
    endtask

    task automatic model_step(input logic [FL-1:0] cc, input logic [FL-1:0] hu,
                              input logic [FL-1:0] hd, input logic hold);
        int  cf, pref;
        bit  su, sd;
        cf = -1; su = 1'b0; sd = 1'b0;
        if (m_door) begin
            su = serves(m_floor, m_dir, 1);
            sd = serves(m_floor, m_dir, -1);
            cf = m_floor;
            if (hold || cc[m_floor] || (hu[m_floor] && m_floor != FL-1 && su) ||
                (hd[m_floor] && m_floor != 0 && sd))
                m_left = DT;
            else if (m_left == 1)
                m_door = 1'b0;
            else
                m_left--;
        end else if (m_move) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                m_floor += m_dir;
                if (pc[m_floor] || (m_dir > 0 ? pu[m_floor] : pd[m_floor]) ||
                    !ahead(m_floor, m_dir) || m_floor == 0 || m_floor == FL-1) begin
                    m_move = 1'b0; m_door = 1'b1; m_left = DT; cf = m_floor;
                    su = serves(m_floor, m_dir, 1);
                    sd = serves(m_floor, m_dir, -1);
                end else begin
                    m_left = TT;
                end
            end
        end else begin
            su = serves(m_floor, m_dir, 1);
            sd = serves(m_floor, m_dir, -1);
            if (pc[m_floor] || (pu[m_floor] && su) || (pd[m_floor] && sd)) begin
                m_door = 1'b1; m_left = DT; cf = m_floor;
            end else begin
                pref = (m_dir == 0) ? 1 : m_dir;
                if (ahead(m_floor, pref)) begin
                    m_dir = pref; m_move = 1'b1; m_left = TT;
                end else if (ahead(m_floor, -pref)) begin
                    m_dir = -pref; m_move = 1'b1; m_left = TT;
                end else begin
                    m_dir = 0;
                end
            end
        end
        for (int g = 0; g < FL; g++) begin
            pc[g] = (pc[g] || cc[g]) && !(g == cf);
            pu[g] = (pu[g] || (hu[g] && g != FL-1)) && !(g == cf && su);
            pd[g] = (pd[g] || (hd[g] && g != 0)) && !(g == cf && sd);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [FL-1:0] vc, vu, vd;
        for (int g = 0; g < FL; g++) begin
            vc[g] = pc[g]; vu[g] = pu[g]; vd[g] = pd[g];
        end
        chk("floor_pos", 32'(floor_pos), 32'(m_floor));
        chk("door_open", 32'(door_open), 32'(m_door));
        chk("move_up",   32'(move_up),   32'(m_move && m_dir > 0));
        chk("move_dn",   32'(move_dn),   32'(m_move && m_dir < 0));
        chk("pend_car",  32'(pend_car),  32'(vc));
        chk("pend_up",   32'(pend_up),   32'(vu));
        chk("pend_dn",   32'(pend_dn),   32'(vd));
    endtask

    // Entered just after a rising edge; tallies the current cycle, drives, steps, checks.
    task automatic tick(input logic [FL-1:0] cc, input logic [FL-1:0] hu,
                        input logic [FL-1:0] hd, input logic hold);
        cnt_up   += int'(move_up);
        cnt_dn   += int'(move_dn);
        cnt_door += int'(door_open);
        car_call = cc; hall_up = hu; hall_dn = hd; door_hold = hold;
        model_step(cc, hu, hd, hold);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, '0, '0, 1'b0);
    endtask

    task automatic clr_cnt();
        cnt_up = 0; cnt_dn = 0; cnt_door = 0;
    endtask

    task automatic do_reset();
        car_call = '0; hall_up = '0; hall_dn = '0; door_hold = 1'b0;
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_cnt();
    endtask

    initial begin
        car_call = '0; hall_up = '0; hall_dn = '0; door_hold = 1'b0;
        rst_n = 1'b0;
        m_reset();
        clr_cnt();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();

        // Single car call to floor 2: two floors of travel, one full dwell.
        tick(4'b0100, '0, '0, 1'b0);
        idle(24);
        chk("s1_up_cycles",   32'(cnt_up),   32'(2 * TT));
        chk("s1_dn_cycles",   32'(cnt_dn),   32'(0));
        chk("s1_door_cycles", 32'(cnt_door), 32'(DT));
        chk("s1_floor",       32'(floor_pos), 32'(2));
        chk("s1_pend_car",    32'(pend_car), 32'(0));

        // Door hold in dwell cycle 6 restarts the full dwell.
        clr_cnt();
        tick(4'b0100, '0, '0, 1'b0);
        idle(6);
        tick('0, '0, '0, 1'b1);
        idle(10);
        chk("hold_door_cycles", 32'(cnt_door), 32'(6 + DT));

        // Car call 1 plus hall down at 3: stop at 1, continue to 3.
        do_reset();
        tick(4'b0010, '0, 4'b1000, 1'b0);
        idle(40);
        chk("s2_floor",       32'(floor_pos), 32'(3));
        chk("s2_up_cycles",   32'(cnt_up),   32'(3 * TT));
        chk("s2_door_cycles", 32'(cnt_door), 32'(2 * DT));
        chk("s2_pend_dn",     32'(pend_dn),  32'(0));

        // Car call 3 with hall down at 1: pass 1 going up, serve it after reversing.
        do_reset();
        tick(4'b1000, '0, 4'b0010, 1'b0);
        idle(60);
        chk("s3_floor",       32'(floor_pos), 32'(1));
        chk("s3_up_cycles",   32'(cnt_up),   32'(3 * TT));
        chk("s3_dn_cycles",   32'(cnt_dn),   32'(2 * TT));
        chk("s3_door_cycles", 32'(cnt_door), 32'(2 * DT));

        // Out-of-range hall buttons are ignored.
        do_reset();
        tick('0, 4'b1000, 4'b0001, 1'b0);
        idle(5);
        chk("mask_pend_up",  32'(pend_up),  32'(0));
        chk("mask_pend_dn",  32'(pend_dn),  32'(0));
        chk("mask_activity", 32'(cnt_up + cnt_dn + cnt_door), 32'(0));

        // Asynchronous reset between floors.
        do_reset();
        tick(4'b1000, '0, '0, 1'b0);
        idle(6);
        chk("mid_move_up",    32'(move_up),   32'(1));
        chk("mid_move_floor", 32'(floor_pos), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_floor",    32'(floor_pos), 32'(0));
        chk("arst_move_up",  32'(move_up),   32'(0));
        chk("arst_door",     32'(door_open), 32'(0));
        chk("arst_pend_car", 32'(pend_car),  32'(0));
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_cnt();

        // Random sparse calls and holds against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [FL-1:0] rc, ru, rd;
            logic          rh;
            rc = ($urandom_range(0, 11) == 0) ? FL'($urandom) : '0;
            ru = ($urandom_range(0, 15) == 0) ? FL'($urandom) : '0;
            rd = ($urandom_range(0, 15) == 0) ? FL'($urandom) : '0;
            rh = ($urandom_range(0, 39) == 0);
            tick(rc, ru, rd, rh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
